// File: rtl/apb_reg_slave.sv
// -----------------------------------------------------------------------------
// apb_reg_slave
//
// Purpose:
//   APB slave register bank. Offers NUM_REGS 32-bit word registers with
//   byte-lane writes (PSTRB) and a fixed number of PREADY-low wait states per
//   transfer. Register 0 is a read-only ID word. PREADY, PRDATA and PSLVERR are
//   all driven from flops.
//
// Ports:
//   clk      in   1            clock, rising edge
//   PRESETn  in   1            asynchronous active-low reset
//   PSELx    in   1            slave select
//   PENABLE  in   1            access phase indicator
//   PWRITE   in   1            1 = write, 0 = read
//   PADDR    in   ADDR_WIDTH   byte address
//   PPROT    in   3            protection attributes (accepted, ignored)
//   PWDATA   in   DATA_WIDTH   write data
//   PSTRB    in   PSTRB_WIDTH  write byte strobes
//   PRDATA   out  DATA_WIDTH   read data, valid only while PREADY = 1
//   PSLVERR  out  1            transfer error, valid only while PREADY = 1
//   PREADY   out  1            transfer completion (one-cycle pulse)
// -----------------------------------------------------------------------------
module apb_reg_slave #(
   parameter int unsigned          ADDR_WIDTH  = 32,
   parameter int unsigned          DATA_WIDTH  = 32,
   parameter int unsigned          PSTRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned          NUM_REGS    = 16,
   parameter int unsigned          WAIT_STATES = 2,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5B0_0001
) (
   input  logic                   clk,
   input  logic                   PRESETn,
   input  logic                   PSELx,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [ADDR_WIDTH-1:0]  PADDR,
   input  logic [2:0]             PPROT,
   input  logic [DATA_WIDTH-1:0]  PWDATA,
   input  logic [PSTRB_WIDTH-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]  PRDATA,
   output logic                   PSLVERR,
   output logic                   PREADY
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   // First byte address past the register window.
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
   localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // ---------------------------------------------------------------------------
   // State and latched transfer
   // ---------------------------------------------------------------------------
   logic [1:0]             r_state;
   logic [1:0]             w_state_next;
   logic [3:0]             r_cnt;
   logic [3:0]             w_cnt_next;

   logic [IDX_W-1:0]       r_idx;
   logic                   r_write;
   logic                   r_err;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [PSTRB_WIDTH-1:0] r_strb;

   logic                   r_pready;
   logic                   r_pslverr;
   logic [DATA_WIDTH-1:0]  r_prdata;

   // Protection attributes carry no meaning for this register bank.
   logic                   w_unused_pprot;
   assign w_unused_pprot = ^PPROT;

   // ---------------------------------------------------------------------------
   // Setup-phase decode
   // ---------------------------------------------------------------------------
   logic                   w_setup;
   logic [IDX_W-1:0]       w_setup_idx;
   logic                   w_setup_err;

   // Only a genuine setup phase (PENABLE low) starts a transfer; a select seen
   // with PENABLE already high in IDLE is a protocol violation and is ignored.
   assign w_setup     = PSELx & ~PENABLE;
   assign w_setup_idx = PADDR[IDX_W+1:2];
   assign w_setup_err = (PADDR[1:0] != 2'b00)
                      | (PADDR >= ADDR_LIMIT)
                      | (PWRITE & (PADDR == '0))
                      | (~PWRITE & (PSTRB != '0));

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_setup) begin
               w_cnt_next   = WAIT_LOAD;
               w_state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!PSELx) begin
               // Master abandoned the transfer: drop it without a response.
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else if (r_cnt == 4'd1) begin
               w_state_next = S_RESP;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Register storage
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] w_reg_view [0:NUM_REGS-1];
   logic                  w_commit;

   // Writes land on the edge that leaves RESP, so an aborted or reset transfer
   // never reaches the registers.
   assign w_commit = (r_state == S_RESP) & r_write & ~r_err;

   assign w_reg_view[0] = ID_VALUE;

   generate
      for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_WIDTH-1:0] r_word;
         logic                  w_hit;

         assign w_hit = w_commit & (r_idx == IDX_W'(gi));

         always_ff @(posedge clk or negedge PRESETn) begin
            if (!PRESETn) begin
               r_word <= '0;
            end else if (w_hit) begin
               for (int bi = 0; bi < PSTRB_WIDTH; bi++) begin
                  if (r_strb[bi]) begin
                     r_word[bi*8 +: 8] <= r_wdata[bi*8 +: 8];
                  end
               end
            end
         end

         assign w_reg_view[gi] = r_word;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Response data selection
   // ---------------------------------------------------------------------------
   // With zero wait states RESP is entered straight from IDLE, so the response
   // must come from the live setup decode rather than the latched copy.
   logic                  w_enter_resp;
   logic [IDX_W-1:0]      w_rd_idx;
   logic                  w_rd_err;
   logic                  w_rd_write;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign w_enter_resp = (w_state_next == S_RESP);
   assign w_rd_idx     = (r_state == S_IDLE) ? w_setup_idx : r_idx;
   assign w_rd_err     = (r_state == S_IDLE) ? w_setup_err : r_err;
   assign w_rd_write   = (r_state == S_IDLE) ? PWRITE      : r_write;
   assign w_rd_data    = w_reg_view[w_rd_idx];

   // ---------------------------------------------------------------------------
   // Control and output flops
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_wdata   <= '0;
         r_strb    <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;

         if ((r_state == S_IDLE) && w_setup) begin
            r_idx   <= w_setup_idx;
            r_write <= PWRITE;
            r_err   <= w_setup_err;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
         end

         // Outputs are only non-zero during the single RESP cycle.
         r_pready  <= w_enter_resp;
         r_pslverr <= w_enter_resp & w_rd_err;
         r_prdata  <= (w_enter_resp & ~w_rd_err & ~w_rd_write) ? w_rd_data : '0;
      end
   end

   assign PREADY  = r_pready;
   assign PSLVERR = r_pslverr;
   assign PRDATA  = r_prdata;

endmodule

// File: tb/tb_apb_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_reg_slave
//
// Purpose:
//   Directed self-checking bench for apb_reg_slave with default parameters
//   (16 registers, 2 wait states, ID 0xA5B0_0001).
// -----------------------------------------------------------------------------
module tb_apb_reg_slave;

   logic        clk = 1'b0;
   logic        PRESETn;
   logic        PSELx;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [2:0]  PPROT;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PSLVERR;
   logic        PREADY;

   int          n_cmp = 0;
   int          n_mis = 0;

   logic [31:0] t_rdata;
   logic        t_err;
   int          t_cyc;
   logic        t_rdy_after;
   int          seen;

   apb_reg_slave dut (
      .clk     (clk),
      .PRESETn (PRESETn),
      .PSELx   (PSELx),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PPROT   (PPROT),
      .PWDATA  (PWDATA),
      .PSTRB   (PSTRB),
      .PRDATA  (PRDATA),
      .PSLVERR (PSLVERR),
      .PREADY  (PREADY)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One APB transfer. Entered and left at 1 time unit after a rising edge.
   // Returns data, error, access-phase length in cycles and PREADY one cycle
   // after completion.
   task automatic apb(input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = wdata;
      PSTRB   = strb;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      t_cyc   = 1;
      while (PREADY !== 1'b1 && t_cyc < 20) begin
         @(posedge clk); #1;
         t_cyc++;
      end
      t_rdata = PRDATA;
      t_err   = PSLVERR;
      @(posedge clk); #1;
      t_rdy_after = PREADY;
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PSTRB   = 4'h0;
      $display("apb %s addr=0x%08h wdata=0x%08h strb=%h -> rdata=0x%08h err=%0b cycles=%0d",
               wr ? "WR" : "RD", addr, wdata, strb, t_rdata, t_err, t_cyc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESETn = 1'b0;
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = '0;
      PPROT   = 3'b000;
      PWDATA  = '0;
      PSTRB   = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pready",  {31'd0, PREADY},  32'd0);
      chk("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
      chk("reset_prdata",  PRDATA,           32'd0);
      PRESETn = 1'b1;
      @(posedge clk); #1;

      // ID register read: PREADY on third access cycle
      apb(1'b0, 32'h00, 32'h0, 4'h0);
      chk("id_rdata", t_rdata, 32'hA5B0_0001);
      chk("id_err",   {31'd0, t_err}, 32'd0);
      chk("id_cycles", t_cyc, 32'd3);
      chk("id_ready_pulse", {31'd0, t_rdy_after}, 32'd0);

      // Full-word write then read back
      apb(1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF);
      chk("wr04_err",    {31'd0, t_err}, 32'd0);
      chk("wr04_cycles", t_cyc, 32'd3);
      apb(1'b0, 32'h04, 32'h0, 4'h0);
      chk("rd04_full", t_rdata, 32'hDEAD_BEEF);

      // Byte-lane write
      apb(1'b1, 32'h04, 32'h1122_3344, 4'b0101);
      apb(1'b0, 32'h04, 32'h0, 4'h0);
      chk("rd04_lanes", t_rdata, 32'hDE22_BE44);

      // Error cases
      apb(1'b0, 32'h40, 32'h0, 4'h0);
      chk("err_range_slverr", {31'd0, t_err}, 32'd1);
      chk("err_range_rdata",  t_rdata, 32'd0);
      apb(1'b0, 32'h06, 32'h0, 4'h0);
      chk("err_align_slverr", {31'd0, t_err}, 32'd1);
      chk("err_align_rdata",  t_rdata, 32'd0);
      apb(1'b1, 32'h00, 32'h5555_5555, 4'hF);
      chk("err_wr0_slverr", {31'd0, t_err}, 32'd1);
      apb(1'b0, 32'h00, 32'h0, 4'h0);
      chk("err_wr0_id_kept", t_rdata, 32'hA5B0_0001);
      apb(1'b0, 32'h08, 32'h0, 4'h1);
      chk("err_rdstrb_slverr", {31'd0, t_err}, 32'd1);
      chk("err_rdstrb_rdata",  t_rdata, 32'd0);
      apb(1'b1, 32'h06, 32'hFFFF_FFFF, 4'hF);
      chk("err_wralign_slverr", {31'd0, t_err}, 32'd1);
      apb(1'b0, 32'h04, 32'h0, 4'h0);
      chk("err_wralign_kept", t_rdata, 32'hDE22_BE44);

      // Last register is in range
      apb(1'b0, 32'h3C, 32'h0, 4'h0);
      chk("last_reg_err",   {31'd0, t_err}, 32'd0);
      chk("last_reg_rdata", t_rdata, 32'd0);

      // Back-to-back write then read
      apb(1'b1, 32'h08, 32'h0000_00FF, 4'hF);
      chk("b2b_wr_cycles", t_cyc, 32'd3);
      chk("b2b_wr_pulse",  {31'd0, t_rdy_after}, 32'd0);
      apb(1'b0, 32'h08, 32'h0, 4'h0);
      chk("b2b_rd_cycles", t_cyc, 32'd3);
      chk("b2b_rd_rdata",  t_rdata, 32'h0000_00FF);
      chk("b2b_rd_pulse",  {31'd0, t_rdy_after}, 32'd0);

      // Deselect during WAIT drops the write
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
      PADDR = 32'h08; PWDATA = 32'hAAAA_AAAA; PSTRB = 4'hF;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(posedge clk); #1;
      PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (PREADY === 1'b1) seen++;
      end
      $display("drop: write 0x08 abandoned in WAIT, PREADY pulses=%0d", seen);
      chk("drop_no_ready", seen, 32'd0);
      apb(1'b0, 32'h08, 32'h0, 4'h0);
      chk("drop_reg_kept", t_rdata, 32'h0000_00FF);

      // Setup with PENABLE already high in IDLE is ignored
      PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h04; PSTRB = 4'h0;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (PREADY === 1'b1) seen++;
      end
      PSELx = 1'b0; PENABLE = 1'b0;
      $display("protocol violation: PREADY pulses=%0d", seen);
      chk("violation_ignored", seen, 32'd0);

      // Reset during WAIT of a write
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
      PADDR = 32'h0C; PWDATA = 32'h1234_5678; PSTRB = 4'hF;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(posedge clk); #2;
      PRESETn = 1'b0;
      #1;
      chk("rst_wait_pready", {31'd0, PREADY}, 32'd0);
      PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_pready", {31'd0, PREADY}, 32'd0);
      PRESETn = 1'b1;
      @(posedge clk); #1;
      $display("reset asserted during WAIT of write 0x0C, released");
      apb(1'b0, 32'h0C, 32'h0, 4'h0);
      chk("rst_0c_zero", t_rdata, 32'd0);
      chk("rst_0c_cycles", t_cyc, 32'd3);
      apb(1'b0, 32'h08, 32'h0, 4'h0);
      chk("rst_08_cleared", t_rdata, 32'd0);

      // Reset while PREADY is high drops it without waiting for a clock edge
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h00; PSTRB = 4'h0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("resp_pready_high", {31'd0, PREADY}, 32'd1);
      chk("resp_prdata_id",   PRDATA, 32'hA5B0_0001);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("rst_resp_pready", {31'd0, PREADY}, 32'd0);
      chk("rst_resp_prdata", PRDATA, 32'd0);
      PSELx = 1'b0; PENABLE = 1'b0;
      @(posedge clk); #1;
      PRESETn = 1'b1;
      @(posedge clk); #1;
      $display("reset asserted during RESP of read 0x00, released");
      apb(1'b0, 32'h00, 32'h0, 4'h0);
      chk("recover_id", t_rdata, 32'hA5B0_0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
